midi_msg_decoder: RTL

Byte-level MIDI message decoder for the badge audio path. It consumes the byte stream from the MIDI UART receiver and emits one-cycle channel-voice events. It handles running status, interleaved realtime bytes and sysex skipping. It also tracks a monophonic "current note" and gate that drive the note-to-increment lookup and the envelope.

---
 rtl/midi_pkg.sv | 39 +++
 rtl/midi_mono_voice.sv | 30 +++
 rtl/midi_msg_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, decoder state and event types, plus the message-length helper.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF    = 4'h8;
   localparam logic [3:0] NOTE_ON     = 4'h9;
   localparam logic [3:0] POLY_AT     = 4'hA;
   localparam logic [3:0] CC          = 4'hB;
   localparam logic [3:0] PROG        = 4'hC;
   localparam logic [3:0] CHAN_AT     = 4'hD;
   localparam logic [3:0] PBEND       = 4'hE;
   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_D1,
      WAIT_D2,
      SYSEX
   } dec_state_t;

   typedef enum logic [2:0] {
      EVT_NOTE_OFF = 3'd0,
      EVT_NOTE_ON  = 3'd1,
      EVT_POLY_AT  = 3'd2,
      EVT_CC       = 3'd3,
      EVT_PROG     = 3'd4,
      EVT_CHAN_AT  = 3'd5,
      EVT_PBEND    = 3'd6
   } evt_type_t;

   function automatic logic [1:0] midi_data_len(input logic [7:0] status);
      if (status[7:4] == PROG || status[7:4] == CHAN_AT)
         return 2'd1;
      else
         return 2'd2;
   endfunction

endpackage

// File: rtl/midi_mono_voice.sv
// Monophonic note/gate tracker fed by the decoder's pre-register event bus,
// so its outputs change in the same cycle the registered event strobe rises.
module midi_mono_voice
   import midi_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       evt_valid,
   input  logic [2:0] evt_type,
   input  logic [6:0] evt_d1,
   input  logic [6:0] evt_d2,
   output logic [6:0] mono_note,
   output logic       mono_gate
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mono_note <= '0;
         mono_gate <= 1'b0;
      end else if (evt_valid) begin
         if (evt_type == EVT_NOTE_ON && evt_d2 != 7'd0) begin
            mono_note <= evt_d1;
            mono_gate <= 1'b1;
         end else if (evt_type == EVT_NOTE_OFF && evt_d1 == mono_note) begin
            mono_gate <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream decoder: running status, realtime pass-through, sysex skip,
// optional channel filter, one-cycle registered channel-voice events.
module midi_msg_decoder
   import midi_pkg::*;
#(
   parameter bit OMNI = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic [3:0] listen_chan,
   output logic       evt_valid,
   output logic [2:0] evt_type,
   output logic [3:0] evt_chan,
   output logic [6:0] evt_d1,
   output logic [6:0] evt_d2,
   output logic [6:0] mono_note,
   output logic       mono_gate
);

   dec_state_t state_reg, state_next;
   logic [7:0] rs_reg, rs_next;
   logic       rs_valid_reg, rs_valid_next;
   logic [6:0] d1_reg, d1_next;

   logic       emit;
   logic       fire;
   logic [2:0] emit_type;
   logic [6:0] emit_d1;
   logic [6:0] emit_d2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         rs_reg       <= '0;
         rs_valid_reg <= 1'b0;
         d1_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         rs_reg       <= rs_next;
         rs_valid_reg <= rs_valid_next;
         d1_reg       <= d1_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      rs_next       = rs_reg;
      rs_valid_next = rs_valid_reg;
      d1_next       = d1_reg;
      emit          = 1'b0;
      emit_d1       = byte_in[6:0];
      emit_d2       = 7'd0;
      if (byte_valid) begin
         if (byte_in >= RT_MIN) begin
            // realtime bytes are invisible to the parser
         end else if (byte_in[7] && byte_in < SYSEX_START) begin
            rs_next       = byte_in;
            rs_valid_next = 1'b1;
            state_next    = WAIT_D1;
         end else if (byte_in == SYSEX_START) begin
            rs_valid_next = 1'b0;
            state_next    = SYSEX;
         end else if (byte_in[7]) begin
            rs_valid_next = 1'b0;
            state_next    = IDLE;
         end else begin
            case (state_reg)
               IDLE, WAIT_D1: begin
                  if (rs_valid_reg) begin
                     if (midi_data_len(rs_reg) == 2'd1) begin
                        emit       = 1'b1;
                        state_next = WAIT_D1;
                     end else begin
                        d1_next    = byte_in[6:0];
                        state_next = WAIT_D2;
                     end
                  end
               end
               WAIT_D2: begin
                  emit       = 1'b1;
                  emit_d1    = d1_reg;
                  emit_d2    = byte_in[6:0];
                  state_next = WAIT_D1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      emit_type = rs_reg[6:4];
      if (rs_reg[7:4] == NOTE_ON && emit_d2 == 7'd0)
         emit_type = EVT_NOTE_OFF;
   end

   // Filtered-out channels still advance the parser; they just never strobe.
   assign fire = emit && (OMNI || rs_reg[3:0] == listen_chan);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         evt_valid <= 1'b0;
         evt_type  <= '0;
         evt_chan  <= '0;
         evt_d1    <= '0;
         evt_d2    <= '0;
      end else begin
         evt_valid <= fire;
         if (fire) begin
            evt_type <= emit_type;
            evt_chan <= rs_reg[3:0];
            evt_d1   <= emit_d1;
            evt_d2   <= emit_d2;
         end
      end
   end

   midi_mono_voice u_mono (
      .clk       (clk),
      .reset_n   (reset_n),
      .evt_valid (fire),
      .evt_type  (emit_type),
      .evt_d1    (emit_d1),
      .evt_d2    (emit_d2),
      .mono_note (mono_note),
      .mono_gate (mono_gate)
   );

endmodule
